// File: rtl/whack_mole_engine.sv
// Whack-a-mole game core: N moles with per-mole lifetimes, switch-edge whack detection,
// saturating hit/miss/wrong counters and an IDLE/PLAY/OVER game FSM.
// Latency: fully registered, so a switch edge at cycle t shows up on pulses, LEDs and counts at t+1.
// Backpressure: none; every input is consumed in the cycle it is presented.
//
// Ports: clk, rst_n (sync, active-low), start (begin/restart pulse), tick (game-rate strobe),
//        sw (debounced switches), spawn (pop-up requests, used on tick only),
//        mole_led, hit_pulse, miss_pulse, hit_count, miss_count, wrong_count, playing, game_over.
// Optional macro WHACK_STREAK_EN adds streak and best_streak outputs.
module whack_mole_engine #(
    parameter int N_MOLES    = 18,
    parameter int LIFE_TICKS = 4,
    parameter int LIFE_W     = 3,
    parameter int CNT_W      = 8,
    parameter int MAX_MISS   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tick,
    input  logic [N_MOLES-1:0] sw,
    input  logic [N_MOLES-1:0] spawn,
    output logic [N_MOLES-1:0] mole_led,
    output logic [N_MOLES-1:0] hit_pulse,
    output logic [N_MOLES-1:0] miss_pulse,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count,
    output logic [CNT_W-1:0]   wrong_count,
    output logic               playing,
`ifdef WHACK_STREAK_EN
    output logic [CNT_W-1:0]   streak,
    output logic [CNT_W-1:0]   best_streak,
`endif
    output logic               game_over
);

    localparam int PC_W  = $clog2(N_MOLES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [LIFE_W-1:0] LIFE_ONE = LIFE_W'(1);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [PC_W-1:0] popcnt(input logic [N_MOLES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[CNT_W-1:0];
    endfunction

    state_t                          state_q, state_d;
    logic [N_MOLES-1:0]              sw_prev_q, sw_prev_d;
    logic [N_MOLES-1:0]              active_q, active_d;
    logic [N_MOLES-1:0][LIFE_W-1:0]  life_q, life_d;
    logic [N_MOLES-1:0]              hit_pulse_q, hit_pulse_d;
    logic [N_MOLES-1:0]              miss_pulse_q, miss_pulse_d;
    logic [CNT_W-1:0]                hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]                wrong_cnt_q, wrong_cnt_d;
`ifdef WHACK_STREAK_EN
    logic [CNT_W-1:0]                streak_q, streak_d;
    logic [CNT_W-1:0]                best_q, best_d;
    logic [CNT_W-1:0]                streak_n;
`endif

    // Per-mole event decode and the mole state that PLAY would produce.
    logic [N_MOLES-1:0]              whack;
    logic [N_MOLES-1:0]              hit_v, wrong_v, expire_v, spawn_v;
    logic [N_MOLES-1:0]              active_n;
    logic [N_MOLES-1:0][LIFE_W-1:0]  life_n;

    always_comb begin
        whack    = sw ^ sw_prev_q;
        hit_v    = '0;
        wrong_v  = '0;
        expire_v = '0;
        spawn_v  = '0;
        active_n = active_q;
        life_n   = life_q;
        for (int i = 0; i < N_MOLES; i++) begin
            hit_v[i]    = whack[i] & active_q[i];
            wrong_v[i]  = whack[i] & ~active_q[i];
            // A hit on the expiring tick wins: no miss for that mole.
            expire_v[i] = tick & active_q[i] & ~hit_v[i] & (life_q[i] == LIFE_ONE);
            // An expiring mole counts as free, so it may pop up again on the same tick.
            // Spawning onto a still-active mole never reloads its life.
            spawn_v[i]  = tick & spawn[i] & ~hit_v[i] & (~active_q[i] | expire_v[i]);
            if (hit_v[i]) begin
                active_n[i] = 1'b0;
                life_n[i]   = '0;
            end else if (spawn_v[i]) begin
                active_n[i] = 1'b1;
                life_n[i]   = LIFE_INIT;
            end else if (expire_v[i]) begin
                active_n[i] = 1'b0;
                life_n[i]   = '0;
            end else if (tick && active_q[i] && (life_q[i] > LIFE_ONE)) begin
                life_n[i]   = life_q[i] - LIFE_ONE;
            end
        end
    end

`ifdef WHACK_STREAK_EN
    // A miss or wrong whack anywhere in the cycle wipes the streak, even if hits also landed.
    always_comb begin
        streak_n = streak_q;
        if ((expire_v != '0) || (wrong_v != '0)) begin
            streak_n = '0;
        end else begin
            streak_n = sat_add(streak_q, popcnt(hit_v));
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        sw_prev_d    = sw;
        active_d     = active_q;
        life_d       = life_q;
        hit_pulse_d  = '0;
        miss_pulse_d = '0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wrong_cnt_d  = wrong_cnt_q;
`ifdef WHACK_STREAK_EN
        streak_d     = streak_q;
        best_d       = best_q;
`endif
        if (start) begin
            // Fresh game from any state; whacks in this cycle are dropped.
            state_d     = ST_PLAY;
            active_d    = '0;
            life_d      = '0;
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
            wrong_cnt_d = '0;
`ifdef WHACK_STREAK_EN
            streak_d    = '0;
            best_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    active_d = '0;
                    life_d   = '0;
                end
                ST_PLAY: begin
                    if (miss_cnt_q >= CNT_W'(MAX_MISS)) begin
                        // Miss limit became visible last cycle: close the game without
                        // scoring further events so the final counts match what was shown.
                        state_d  = ST_OVER;
                        active_d = '0;
                        life_d   = '0;
                    end else begin
                        active_d     = active_n;
                        life_d       = life_n;
                        hit_pulse_d  = hit_v;
                        miss_pulse_d = expire_v;
                        hit_cnt_d    = sat_add(hit_cnt_q, popcnt(hit_v));
                        miss_cnt_d   = sat_add(miss_cnt_q, popcnt(expire_v));
                        wrong_cnt_d  = sat_add(wrong_cnt_q, popcnt(wrong_v));
`ifdef WHACK_STREAK_EN
                        streak_d     = streak_n;
                        best_d       = (streak_n > best_q) ? streak_n : best_q;
`endif
                    end
                end
                ST_OVER: begin
                    active_d = '0;
                    life_d   = '0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    active_d = '0;
                    life_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // Switch history follows sw even in reset so releasing reset never looks like a whack.
        sw_prev_q <= sw_prev_d;
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            active_q     <= '0;
            life_q       <= '0;
            hit_pulse_q  <= '0;
            miss_pulse_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            wrong_cnt_q  <= '0;
`ifdef WHACK_STREAK_EN
            streak_q     <= '0;
            best_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            life_q       <= life_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            wrong_cnt_q  <= wrong_cnt_d;
`ifdef WHACK_STREAK_EN
            streak_q     <= streak_d;
            best_q       <= best_d;
`endif
        end
    end

    assign mole_led    = active_q;
    assign hit_pulse   = hit_pulse_q;
    assign miss_pulse  = miss_pulse_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;
    assign wrong_count = wrong_cnt_q;
    assign playing     = (state_q == ST_PLAY);
    assign game_over   = (state_q == ST_OVER);
`ifdef WHACK_STREAK_EN
    assign streak      = streak_q;
    assign best_streak = best_q;
`endif

endmodule

// File: tb/tb_whack_mole_engine.sv
// Directed bench for whack_mole_engine: a default-size instance for the game flow and a
// small instance (4 moles, 3-bit counters) for counter saturation and the optional streak.
module tb_whack_mole_engine;

    localparam int N  = 18;
    localparam int NS = 4;
    localparam int CS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, tick;
    logic [N-1:0] sw, spawn;
    logic [N-1:0] mole_led, hit_pulse, miss_pulse;
    logic [7:0]   hit_count, miss_count, wrong_count;
    logic         playing, game_over;
`ifdef WHACK_STREAK_EN
    logic [7:0]   streak, best_streak;
`endif

    logic          s_start, s_tick;
    logic [NS-1:0] s_sw, s_spawn;
    logic [NS-1:0] s_mole_led, s_hit_pulse, s_miss_pulse;
    logic [CS-1:0] s_hit_count, s_miss_count, s_wrong_count;
    logic          s_playing, s_game_over;
`ifdef WHACK_STREAK_EN
    logic [CS-1:0] s_streak, s_best_streak;
`endif

    whack_mole_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .sw(sw), .spawn(spawn),
        .mole_led(mole_led), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .hit_count(hit_count), .miss_count(miss_count), .wrong_count(wrong_count),
        .playing(playing),
`ifdef WHACK_STREAK_EN
        .streak(streak), .best_streak(best_streak),
`endif
        .game_over(game_over)
    );

    whack_mole_engine #(.N_MOLES(NS), .LIFE_TICKS(4), .LIFE_W(3), .CNT_W(CS), .MAX_MISS(7)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .tick(s_tick), .sw(s_sw), .spawn(s_spawn),
        .mole_led(s_mole_led), .hit_pulse(s_hit_pulse), .miss_pulse(s_miss_pulse),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .wrong_count(s_wrong_count),
        .playing(s_playing),
`ifdef WHACK_STREAK_EN
        .streak(s_streak), .best_streak(s_best_streak),
`endif
        .game_over(s_game_over)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input logic [N-1:0] m);
        tick  = 1'b1;
        spawn = m;
        cyc();
        tick  = 1'b0;
        spawn = '0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tick = 1'b0; spawn = '0; sw = 18'h3FFFF;
        s_start = 1'b0; s_tick = 1'b0; s_spawn = '0; s_sw = '0;
        cyc(); cyc();
        chk("rst_led", 32'(mole_led), 32'h0);
        chk("rst_hit", 32'(hit_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_wrong", 32'(wrong_count), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_hitp", 32'(hit_pulse), 32'h0);

        // Release reset with switches held high, then start while flipping sw[1].
        rst_n = 1'b1;
        cyc();
        chk("idle_wrong", 32'(wrong_count), 32'd0);
        start = 1'b1; sw = sw ^ 18'h2;
        cyc();
        start = 1'b0;
        chk("start_playing", 32'(playing), 32'd1);
        chk("start_wrong", 32'(wrong_count), 32'd0);
        chk("start_led", 32'(mole_led), 32'h0);
        cyc();
        chk("start_wrong2", 32'(wrong_count), 32'd0);

        // Hit on mole 0.
        tk(18'h1);
        chk("hit_led_up", 32'(mole_led), 32'h1);
        sw = sw ^ 18'h1;
        cyc();
        chk("hit_led_clr", 32'(mole_led), 32'h0);
        chk("hit_pulse", 32'(hit_pulse), 32'h1);
        chk("hit_count1", 32'(hit_count), 32'd1);
        cyc();
        chk("hit_pulse_1cyc", 32'(hit_pulse), 32'h0);

        // Expiry of mole 5 with re-spawn on the expiring tick.
        tk(18'h20);
        chk("exp_led_up", 32'(mole_led), 32'h20);
        tk('0); tk('0); tk('0);
        chk("exp_led_t3", 32'(mole_led), 32'h20);
        chk("exp_nomiss_t3", 32'(miss_pulse), 32'h0);
        tk(18'h20);
        chk("exp_missp", 32'(miss_pulse), 32'h20);
        chk("exp_miss1", 32'(miss_count), 32'd1);
        chk("exp_respawn", 32'(mole_led), 32'h20);
        cyc();
        chk("exp_missp_1cyc", 32'(miss_pulse), 32'h0);
        sw = sw ^ 18'h20;
        cyc();
        chk("hit5_count", 32'(hit_count), 32'd2);
        chk("hit5_led", 32'(mole_led), 32'h0);

        // Wrong whacks, single then two at once.
        sw = sw ^ 18'h8;
        cyc();
        chk("wrong1", 32'(wrong_count), 32'd1);
        chk("wrong1_hits", 32'(hit_count), 32'd2);
        sw = sw ^ 18'h18;
        cyc();
        chk("wrong3", 32'(wrong_count), 32'd3);

        // Whack on the expiring tick of mole 2: hit wins.
        tk(18'h4);
        chk("sim_led_up", 32'(mole_led), 32'h4);
        tk('0); tk('0); tk('0);
        tick = 1'b1; sw = sw ^ 18'h4;
        cyc();
        tick = 1'b0;
        chk("sim_hitp", 32'(hit_pulse), 32'h4);
        chk("sim_missp", 32'(miss_pulse), 32'h0);
        chk("sim_hit", 32'(hit_count), 32'd3);
        chk("sim_miss", 32'(miss_count), 32'd1);
        chk("sim_led", 32'(mole_led), 32'h0);

        // Nine moles expire together: miss_count reaches 10, game ends one cycle later.
        tk(18'h1FF);
        tk('0); tk('0); tk('0);
        tk('0);
        chk("go_missp", 32'(miss_pulse), 32'h1FF);
        chk("go_miss10", 32'(miss_count), 32'd10);
        chk("go_still_play", 32'(playing), 32'd1);
        chk("go_not_over", 32'(game_over), 32'd0);
        cyc();
        chk("go_over", 32'(game_over), 32'd1);
        chk("go_playing", 32'(playing), 32'd0);
        chk("go_led", 32'(mole_led), 32'h0);
        sw = sw ^ 18'h3;
        tk(18'h7);
        chk("frz_hit", 32'(hit_count), 32'd3);
        chk("frz_miss", 32'(miss_count), 32'd10);
        chk("frz_wrong", 32'(wrong_count), 32'd3);
        chk("frz_led", 32'(mole_led), 32'h0);
        chk("frz_hitp", 32'(hit_pulse), 32'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rs_playing", 32'(playing), 32'd1);
        chk("rs_over", 32'(game_over), 32'd0);
        chk("rs_hit", 32'(hit_count), 32'd0);
        chk("rs_miss", 32'(miss_count), 32'd0);
        chk("rs_wrong", 32'(wrong_count), 32'd0);

        // Saturation on the 3-bit instance: 9 hits clamp at 7.
        s_start = 1'b1;
        cyc();
        s_start = 1'b0;
        chk("s_playing", 32'(s_playing), 32'd1);
        for (int k = 0; k < 9; k++) begin
            s_tick = 1'b1; s_spawn = 4'h1;
            cyc();
            s_tick = 1'b0; s_spawn = '0;
            chk("s_led_up", 32'(s_mole_led), 32'h1);
            s_sw = s_sw ^ 4'h1;
            cyc();
        end
        chk("s_hit_sat", 32'(s_hit_count), 32'd7);
        chk("s_miss0", 32'(s_miss_count), 32'd0);
`ifdef WHACK_STREAK_EN
        chk("s_streak7", 32'(s_streak), 32'd7);
        chk("s_best7", 32'(s_best_streak), 32'd7);
`endif
        s_sw = s_sw ^ 4'h2;
        cyc();
        chk("s_wrong1", 32'(s_wrong_count), 32'd1);
        chk("s_hit_hold", 32'(s_hit_count), 32'd7);
`ifdef WHACK_STREAK_EN
        chk("s_streak0", 32'(s_streak), 32'd0);
        chk("s_best_keep", 32'(s_best_streak), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/whack_mole_engine.md
Name: whack_mole_engine

Overview:
- Parametrised, fully registered whack-a-mole game core for N independent moles.
- Per-mole lifetime counters expire unhit moles as misses. Switch toggles are detected as whacks.
- Hits, misses and wrong whacks are counted, and a game FSM ends play after MAX_MISS misses.
- Sits between the LFSR spawn source and the score/7-seg display logic; drives the LEDs directly.

Parameters:
- N_MOLES, 18, number of moles, switches and LEDs.
- LIFE_TICKS, 4, ticks a mole stays up before expiring (1..2^LIFE_W-1).
- LIFE_W, 3, lifetime counter width.
- CNT_W, 8, width of the hit, miss and wrong counters (saturating).
- MAX_MISS, 10, miss count that ends the game (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins (or restarts) a game
- tick  in  1  one-cycle game-rate strobe (e.g. 1 s divider)
- sw  in  N_MOLES  switch inputs, already debounced
- spawn  in  N_MOLES  moles requested to pop up; sampled only when tick=1
- mole_led  out  N_MOLES  currently active moles
- hit_pulse  out  N_MOLES  one-cycle pulse per mole hit
- miss_pulse  out  N_MOLES  one-cycle pulse per mole expired
- hit_count  out  CNT_W  total hits this game
- miss_count  out  CNT_W  total misses this game
- wrong_count  out  CNT_W  whacks on empty holes this game
- playing  out  1  FSM in PLAY
- game_over  out  1  FSM in OVER

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM enters IDLE.
  - All outputs become 0 and all life counters become 0.
  - sw_prev is loaded with sw, so no false whack occurs on release.
  - Reset mid-game discards all state.
- sw_prev <= sw every cycle, in all states.
- whack = sw ^ sw_prev (combinational).
- FSM states:
  - IDLE: moles off, counters held.
  - start -> PLAY.
  - PLAY -> OVER in the cycle after miss_count reaches MAX_MISS.
  - OVER: moles cleared, counters frozen.
  - start in OVER -> PLAY.
  - start in PLAY restarts the game.
- Entering PLAY (the start cycle):
  - All counters, life counters, mole_led and pulses are cleared.
  - Whacks in the start cycle are ignored.
- PLAY, per mole i, evaluated each cycle with this priority:
  1. Hit: whack[i] & active[i] -> hit_pulse[i]=1 next cycle, mole cleared, life=0.
  2. Wrong: whack[i] & !active[i] -> wrong_count +1 (summed over all wrong bits in that cycle).
  3. Expire: tick & active[i] & life[i]==1 -> miss_pulse[i]=1, mole cleared.
  4. Decrement: tick & active[i] & life[i]>1 -> life[i]-1.
  5. Spawn: tick & spawn[i] & !active[i] & no hit[i] that cycle -> active, life=LIFE_TICKS.
- Spawn and hit interactions:
  - Spawn on an already-active mole is ignored; it does not reload life.
  - A mole expired in a tick may re-spawn in the same tick.
- Same-cycle events: whack and expiry on the same mole -> hit wins and no miss is counted.
- Counters:
  - hit_count += popcount(hits), miss_count += popcount(expires), wrong_count += popcount(wrongs).
  - Each counter saturates at 2^CNT_W-1; there is no wrap.
- Latency: all outputs are registered; a switch edge at cycle t produces hit_pulse, LED clear and count update at t+1.
- Pulse widths: hit_pulse and miss_pulse are exactly one cycle. They are 0 outside PLAY.
- No multi-mole limit: any subset of moles may be active simultaneously.

Optional Feature:
- Macro: WHACK_STREAK_EN.
- When defined, two extra ports are added:
  - streak out CNT_W: consecutive hits without a miss or wrong whack.
  - best_streak out CNT_W: maximum streak this game.
- Streak rules:
  - streak += popcount(hits) and saturates at 2^CNT_W-1.
  - streak clears to 0 on any miss or wrong whack in a cycle, overriding hits in that same cycle.
  - best_streak updates to max(best_streak, new streak) in the same cycle.
- Both are cleared on reset and on start, and frozen in OVER.
- When not defined, neither port nor logic exists.

Test Plan:
- Reset/start: rst_n low 2 cycles with sw=18'h3FFFF, release, start pulse -> all counts 0, mole_led=0, playing=1, no wrong whacks counted.
- Hit: tick with spawn=18'h00001, next cycle toggle sw[0] -> mole_led[0] 1→0 one cycle after toggle, hit_pulse=18'h00001 for 1 cycle, hit_count=1.
- Expiry: spawn bit 5, no whack, 4 ticks -> miss_pulse[5] on 4th tick, miss_count=1; re-spawn in that tick -> mole_led[5] stays 1.
- Wrong/simultaneous: toggle sw[3] with no mole -> wrong_count=1; toggle sw[2] in the cycle of its expiring tick -> hit_count +1, miss_count unchanged.
- Game over: MAX_MISS=10, let 10 moles expire -> game_over=1 one cycle after miss_count=10, mole_led=0, further toggles leave counts frozen; start -> PLAY with counts 0.
- Saturation (CNT_W=3), with WHACK_STREAK_EN: 9 hits -> hit_count=7, streak=7; then 1 wrong -> streak=0, best_streak=7.
